// File: rtl/display_timing_pkg.sv
// Shared raster definitions: pixel colour layout and total-period helpers,
// also used by the camera to size its scan counters.
package display_timing;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } colour_t;

  function automatic int unsigned h_total(input int unsigned width, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return width + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned width, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return width + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_output_raster_counter.sv
// Horizontal/vertical raster position counters; vertical advances on the
// horizontal wrap. Both advance only while enabled.
module raster_counter #(
  parameter int unsigned H_TOTAL = 14,
  parameter int unsigned V_TOTAL = 7,
  parameter int unsigned HW      = $clog2(H_TOTAL),
  parameter int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          h_wrap,
  output logic          v_wrap
);

  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;

  assign h_wrap  = (h_count_q == HW'(H_TOTAL - 1));
  assign v_wrap  = (v_count_q == VW'(V_TOTAL - 1));
  assign h_count = h_count_q;
  assign v_count = v_count_q;

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (en) begin
      h_count_d = h_wrap ? '0 : h_count_q + 1'b1;
      if (h_wrap) begin
        v_count_d = v_wrap ? '0 : v_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

endmodule

// File: rtl/vga_output.sv
// Rebuilds VGA timing around the pipeline's pixel stream: locks the raster to
// the first valid pixel, registers sync/de/rgb, and flags missing active pixels.
module vga_output
  import display_timing::*;
#(
  parameter int unsigned hWidth      = 1680,
  parameter int unsigned hFrontPorch = 48,
  parameter int unsigned hSyncWidth  = 32,
  parameter int unsigned hBackPorch  = 80,
  parameter int unsigned vWidth      = 1050,
  parameter int unsigned vFrontPorch = 3,
  parameter int unsigned vSyncWidth  = 6,
  parameter int unsigned vBackPorch  = 21,
  parameter logic        HSYNC_POL   = 1'b1,
  parameter logic        VSYNC_POL   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  colour_t     in_colour,
  input  logic        underrun_clr,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start,
  output logic        underrun
);

  localparam int unsigned H_TOTAL  = h_total(hWidth, hFrontPorch, hSyncWidth, hBackPorch);
  localparam int unsigned V_TOTAL  = v_total(vWidth, vFrontPorch, vSyncWidth, vBackPorch);
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned H_SYNC_S = hWidth + hFrontPorch;
  localparam int unsigned H_SYNC_E = H_SYNC_S + hSyncWidth;
  localparam int unsigned V_SYNC_S = vWidth + vFrontPorch;
  localparam int unsigned V_SYNC_E = V_SYNC_S + vSyncWidth;

  typedef enum logic {LOCK, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          h_wrap, v_wrap;
  logic          accept, de_next;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q;
  logic          frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic [23:0]   rgb_q, rgb_d;

  // The locking cycle itself is pixel (0,0), so the counters advance on it.
  assign accept = (state_q == RUN) || in_valid;

  raster_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL),
    .HW     (HW),
    .VW     (VW)
  ) u_raster_counter (
    .clk    (pixel_clk),
    .rst_n  (rst_n),
    .en     (accept),
    .h_count(h_count),
    .v_count(v_count),
    .h_wrap (h_wrap),
    .v_wrap (v_wrap)
  );

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOCK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == LOCK && in_valid) state_d = RUN;
  end

  always_comb begin
    de_next       = accept && (32'(h_count) < hWidth) && (32'(v_count) < vWidth);
    hsync_d       = (accept && 32'(h_count) >= H_SYNC_S && 32'(h_count) < H_SYNC_E)
                    ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (accept && 32'(v_count) >= V_SYNC_S && 32'(v_count) < V_SYNC_E)
                    ? VSYNC_POL : ~VSYNC_POL;
    rgb_d         = (de_next && in_valid) ? in_colour : '0;
    frame_start_d = accept && (h_count == '0) && (v_count == '0);
    underrun_d    = underrun_q;
    if (state_q == RUN && de_next && !in_valid) underrun_d = 1'b1;
    else if (underrun_clr)                      underrun_d = 1'b0;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_next;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assert property (@(posedge pixel_clk) disable iff (!rst_n)
    (state_q == RUN && h_wrap && v_wrap) |=> (h_count == '0 && v_count == '0));

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_output.sv
// Directed bench for vga_output with a 14x7 raster (8x4 active).
module tb_vga_output;
  import display_timing::*;

  localparam int H_T = 14;
  localparam int V_T = 7;
  localparam int F_T = H_T * V_T;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  colour_t     in_colour;
  logic        underrun_clr;
  logic        hsync, vsync, de, frame_start, underrun;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  int last_fs = -1;
  int fs_seen = 0;
  bit locked = 0;
  bit und_exp = 0;

  always #5 clk = ~clk;

  vga_output #(
    .hWidth(8), .hFrontPorch(2), .hSyncWidth(2), .hBackPorch(2),
    .vWidth(4), .vFrontPorch(1), .vSyncWidth(1), .vBackPorch(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut (
    .pixel_clk   (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_colour   (in_colour),
    .underrun_clr(underrun_clr),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_active(input int p);
    return ((p % H_T) < 8) && (((p / H_T) % V_T) < 4);
  endfunction

  function automatic int next_pos();
    return locked ? pos + 1 : 0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_hsync"}, hsync, 0);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  // One pixel clock: drive, clock, then compare against the raster model.
  task automatic px(input logic v, input logic clr);
    int h, l;
    logic [23:0] c;
    bit a;
    h = next_pos() % H_T;
    l = (next_pos() / H_T) % V_T;
    c = is_active(next_pos()) ? 24'(l * 8 + h) : 24'hABCDEF;
    in_valid = v;
    in_colour = colour_t'(c);
    underrun_clr = clr;
    @(posedge clk);
    #1;
    if (!locked && v) begin
      locked = 1;
      pos = 0;
    end else if (locked) begin
      pos++;
    end
    if (!locked) begin
      if (clr) und_exp = 0;
      check_idle("idle");
    end else begin
      a = is_active(pos);
      if (a && !v) und_exp = 1;
      else if (clr) und_exp = 0;
      chk("de", de, a);
      chk("rgb", rgb, (a && v) ? c : 24'h0);
      chk("hsync", hsync, (h == 10 || h == 11));
      chk("vsync", vsync, (l != 5));
      chk("frame_start", frame_start, (pos % F_T) == 0);
    end
    chk("underrun", underrun, und_exp);
    if (frame_start === 1'b1) begin
      fs_seen++;
      if (last_fs >= 0) chk("fs_gap", 24'(pos - last_fs), 24'd98);
      last_fs = pos;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int target;
    rst_n = 0;
    in_valid = 0;
    in_colour = colour_t'(24'h0);
    underrun_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_underrun", underrun, 0);
    rst_n = 1;

    repeat (50) px(0, 0);

    // lock and run two full frames
    repeat (2 * F_T) px(1, 0);
    chk("fs_count", 24'(fs_seen), 24'd2);

    // missing active pixel (2,3) of the third frame
    target = 2 * F_T + 3 * H_T + 2;
    while (next_pos() != target) px(1, 0);
    px(0, 0);
    chk("drop_rgb", rgb, 0);
    chk("drop_underrun", underrun, 1);
    repeat (5) px(1, 0);
    chk("sticky_underrun", underrun, 1);
    px(1, 1);
    chk("clr_underrun", underrun, 0);
    while (!is_active(next_pos())) px(1, 0);
    px(0, 1);
    chk("set_wins", underrun, 1);
    px(1, 1);
    chk("clr_again", underrun, 0);

    // valid dropped only in blanking for one whole frame
    while ((next_pos() % F_T) != 0) px(1, 0);
    repeat (F_T) px(is_active(next_pos()), 0);
    chk("blank_drop_underrun", underrun, 0);

    // asynchronous reset in the middle of line 2
    while (((next_pos() / H_T) % V_T) != 2 || (next_pos() % H_T) != 3) px(1, 0);
    px(1, 0);
    chk("pre_reset_de", de, 1);
    #2 rst_n = 0;
    #1;
    check_idle("async_reset");
    chk("async_reset_underrun", underrun, 0);
    locked = 0;
    und_exp = 0;
    last_fs = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) px(0, 0);
    px(1, 0);
    chk("relock_fs", frame_start, 1);
    chk("relock_rgb", rgb, 24'h0);
    repeat (10) px(1, 0);
    chk("relock_line0_end", 24'(pos), 24'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
